// File: rtl/go_sync_n.sv
// go_sync_n: clocked iteration controller for a 4-phase handshake ring.
// It takes one handshake on the outer channel (lr/la). It then runs a
// run-time programmed number of handshakes on the inner channel (rr/ra).
// While it does so it provides the iteration index, a last-iteration flag
// and a one-cycle capture strobe.
// Optional feature macro: GO_SYNC_ABORT_EN adds the abort input and the
// aborted output. An abort ends the transaction early, but only after the
// inner handshake in progress has completed.
module go_sync_n #(
    parameter int CNT_W = 7,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             lr,
    output logic             la,
    input  logic [CNT_W-1:0] iters,
    output logic             rr,
    input  logic             ra,
    output logic [CNT_W-1:0] idx,
    output logic             last,
    output logic             ck
`ifdef GO_SYNC_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1'b1);

`ifdef GO_SYNC_ABORT_EN
    localparam int NIN = 3;
`else
    localparam int NIN = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RTZ  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Raw asynchronous inputs gathered so one synchroniser chain serves all.
    logic [NIN-1:0] in_raw_s;
    logic [NIN-1:0] in_sync_s;
    logic           lr_s;
    logic           ra_s;
    logic           abort_s;

`ifdef GO_SYNC_ABORT_EN
    assign in_raw_s = {abort, ra, lr};
    assign abort_s  = in_sync_s[2];
`else
    assign in_raw_s = {ra, lr};
    assign abort_s  = 1'b0;
`endif
    assign lr_s = in_sync_s[0];
    assign ra_s = in_sync_s[1];

    generate
        if (SYNC == 0) begin : g_nosync
            assign in_sync_s = in_raw_s;
        end else begin : g_sync
            logic [NIN-1:0] sync_r [SYNC];

            // Shift each input through SYNC flops so it is resolved before use.
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    for (int i = 0; i < SYNC; i++) begin
                        sync_r[i] <= '0;
                    end
                end else begin
                    sync_r[0] <= in_raw_s;
                    for (int i = 1; i < SYNC; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign in_sync_s = sync_r[SYNC-1];
        end
    endgenerate

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] lim_r, lim_nx_s;
    logic [CNT_W-1:0] idx_r, idx_nx_s;
    logic             la_r, la_nx_s;
    logic             rr_r, rr_nx_s;
    logic             ck_r, ck_nx_s;
    logic             last_r, last_nx_s;
    logic             abort_pend_r, abort_pend_nx_s;
    logic             aborted_r, aborted_nx_s;

    logic [CNT_W-1:0] lim_m1_s;
    logic [CNT_W-1:0] idx_inc_s;
    logic             abort_hit_s;

    assign lim_m1_s    = lim_r - ONE;
    assign idx_inc_s   = idx_r + ONE;
    assign abort_hit_s = abort_pend_r | abort_s;

    // Next-state and next-output decode; every output is a registered value.
    always_comb begin
        state_nx_s      = state_r;
        lim_nx_s        = lim_r;
        idx_nx_s        = idx_r;
        la_nx_s         = la_r;
        rr_nx_s         = rr_r;
        ck_nx_s         = 1'b0;
        last_nx_s       = last_r;
        abort_pend_nx_s = abort_pend_r;
        aborted_nx_s    = aborted_r;
        case (state_r)
            ST_IDLE: begin
                if (lr_s) begin
                    lim_nx_s = iters;
                    idx_nx_s = '0;
                    if (iters == '0) begin
                        la_nx_s    = 1'b1;
                        state_nx_s = ST_ACK;
                    end else begin
                        rr_nx_s    = 1'b1;
                        last_nx_s  = (iters == ONE);
                        state_nx_s = ST_REQ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                abort_pend_nx_s = abort_hit_s;
                if (ra_s) begin
                    rr_nx_s    = 1'b0;
                    ck_nx_s    = 1'b1;
                    state_nx_s = ST_RTZ;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_RTZ: begin
                abort_pend_nx_s = abort_hit_s;
                if (!ra_s) begin
                    // The handshake is back at zero; finish or start the next one.
                    if ((idx_r == lim_m1_s) || abort_hit_s) begin
                        la_nx_s         = 1'b1;
                        last_nx_s       = 1'b0;
                        aborted_nx_s    = abort_hit_s;
                        abort_pend_nx_s = 1'b0;
                        state_nx_s      = ST_ACK;
                    end else begin
                        idx_nx_s   = idx_inc_s;
                        last_nx_s  = (idx_inc_s == lim_m1_s);
                        rr_nx_s    = 1'b1;
                        state_nx_s = ST_REQ;
                    end
                end else begin
                    state_nx_s = ST_RTZ;
                end
            end
            ST_ACK: begin
                if (!lr_s) begin
                    la_nx_s      = 1'b0;
                    idx_nx_s     = '0;
                    aborted_nx_s = 1'b0;
                    state_nx_s   = ST_IDLE;
                end else begin
                    state_nx_s = ST_ACK;
                end
            end
            default: begin
                state_nx_s      = ST_IDLE;
                la_nx_s         = 1'b0;
                rr_nx_s         = 1'b0;
                last_nx_s       = 1'b0;
                idx_nx_s        = '0;
                abort_pend_nx_s = 1'b0;
                aborted_nx_s    = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r      <= ST_IDLE;
            lim_r        <= '0;
            idx_r        <= '0;
            la_r         <= 1'b0;
            rr_r         <= 1'b0;
            ck_r         <= 1'b0;
            last_r       <= 1'b0;
            abort_pend_r <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            lim_r        <= lim_nx_s;
            idx_r        <= idx_nx_s;
            la_r         <= la_nx_s;
            rr_r         <= rr_nx_s;
            ck_r         <= ck_nx_s;
            last_r       <= last_nx_s;
            abort_pend_r <= abort_pend_nx_s;
            aborted_r    <= aborted_nx_s;
        end
    end

    assign la   = la_r;
    assign rr   = rr_r;
    assign ck   = ck_r;
    assign last = last_r;
    assign idx  = idx_r;
`ifdef GO_SYNC_ABORT_EN
    assign aborted = aborted_r;
`endif

endmodule

// File: tb/tb_go_sync_n.sv
// tb_go_sync_n: directed bench for go_sync_n.
// It uses two instances: one with SYNC=0, driven by a vector table and a
// few hand-written sequences, and one with SYNC=2, which runs a full
// 127-iteration transaction against a randomly delayed partner.
module tb_go_sync_n;

    logic       clk = 1'b0;
    logic       rst_;
    logic       lr0, ra0, la0, rr0, ck0, last0;
    logic [6:0] iters0, idx0;
    logic       lr2, ra2, la2, rr2, ck2, last2;
    logic [6:0] iters2, idx2;
`ifdef GO_SYNC_ABORT_EN
    logic       abort0, aborted0, abort2, aborted2;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       lr;
        logic [6:0] iters;
        logic       ra;
        logic       la;
        logic       rr;
        logic       ck;
        logic       last;
        logic [6:0] idx;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    go_sync_n #(.CNT_W(7), .SYNC(0)) u_s0 (
        .clk(clk), .rst_(rst_), .lr(lr0), .la(la0), .iters(iters0),
        .rr(rr0), .ra(ra0), .idx(idx0), .last(last0), .ck(ck0)
`ifdef GO_SYNC_ABORT_EN
        , .abort(abort0), .aborted(aborted0)
`endif
    );

    go_sync_n #(.CNT_W(7), .SYNC(2)) u_s2 (
        .clk(clk), .rst_(rst_), .lr(lr2), .la(la2), .iters(iters2),
        .rr(rr2), .ra(ra2), .idx(idx2), .last(last2), .ck(ck2)
`ifdef GO_SYNC_ABORT_EN
        , .abort(abort2), .aborted(aborted2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic lr, input logic [6:0] it, input logic ra,
                       input logic la, input logic rr, input logic ck,
                       input logic last, input logic [6:0] idx);
        vec_t v;
        v.lr = lr; v.iters = it; v.ra = ra;
        v.la = la; v.rr = rr; v.ck = ck; v.last = last; v.idx = idx;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] pack0();
        return {21'd0, la0, rr0, ck0, last0, idx0};
    endfunction

    initial begin
        int  ck_cnt;
        int  idx_err;
        int  last_err;
        int  dly;
        bit  done;
        bit  found;

        rst_ = 1'b0;
        lr0 = 1'b0; ra0 = 1'b0; iters0 = 7'd0;
        lr2 = 1'b0; ra2 = 1'b0; iters2 = 7'd0;
`ifdef GO_SYNC_ABORT_EN
        abort0 = 1'b0; abort2 = 1'b0;
`endif

        // Reset state of both instances.
        #12;
        chk("reset_s0", pack0(), 32'd0);
        chk("reset_s2", {21'd0, la2, rr2, ck2, last2, idx2}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        // Asynchronous reset mid-REQ at idx=3.
        @(negedge clk);
        lr0 = 1'b1; iters0 = 7'd8;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rr0 && idx0 == 7'd3) begin
                found = 1'b1;
                break;
            end
            ra0 = rr0;
        end
        chk("reach_idx3", {31'd0, found}, 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("async_reset", pack0(), 32'd0);
        lr0 = 1'b0; ra0 = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", pack0(), 32'd0);
        @(negedge clk);
        lr0 = 1'b1; iters0 = 7'd1;
        @(posedge clk); #1;
        chk("start_after_reset", pack0(), {21'd0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0});
        @(negedge clk); ra0 = 1'b1;
        @(negedge clk); ra0 = 1'b0;
        @(negedge clk);
        chk("la_after_reset_txn", {31'd0, la0}, 32'd1);
        lr0 = 1'b0;
        @(negedge clk);
        chk("la_drop_after_reset_txn", {31'd0, la0}, 32'd0);

        // Vector table for SYNC=0: inputs before an edge, outputs after it.
        //   lr it  ra   la rr ck last idx
        // iters=4 with a same-cycle partner; la comes 9 edges after lr.
        add(1, 4, 0,  0, 1, 0, 0, 0);
        add(1, 4, 1,  0, 0, 1, 0, 0);
        add(1, 4, 0,  0, 1, 0, 0, 1);
        add(1, 4, 1,  0, 0, 1, 0, 1);
        add(1, 4, 0,  0, 1, 0, 0, 2);
        add(1, 4, 1,  0, 0, 1, 0, 2);
        add(1, 4, 0,  0, 1, 0, 1, 3);
        add(1, 4, 1,  0, 0, 1, 1, 3);
        add(1, 4, 0,  1, 0, 0, 0, 3);
        add(0, 4, 0,  0, 0, 0, 0, 0);
        // iters=0: immediate ack with no inner activity.
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0);
        // iters=1: last is high from the start.
        add(1, 1, 0,  0, 1, 0, 1, 0);
        add(1, 1, 1,  0, 0, 1, 1, 0);
        add(1, 1, 0,  1, 0, 0, 0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 0);
        // iters=2, then lr drops early and iters moves to 9: both ignored.
        add(1, 2, 0,  0, 1, 0, 0, 0);
        add(0, 9, 0,  0, 1, 0, 0, 0);
        add(0, 9, 1,  0, 0, 1, 0, 0);
        add(0, 9, 0,  0, 1, 0, 1, 1);
        add(0, 9, 1,  0, 0, 1, 1, 1);
        add(0, 9, 0,  1, 0, 0, 0, 1);
        add(0, 9, 0,  0, 0, 0, 0, 0);
        // Back-to-back: 2 iterations, then 3 starting right after IDLE.
        add(1, 2, 0,  0, 1, 0, 0, 0);
        add(1, 2, 1,  0, 0, 1, 0, 0);
        add(1, 2, 0,  0, 1, 0, 1, 1);
        add(1, 2, 1,  0, 0, 1, 1, 1);
        add(1, 2, 0,  1, 0, 0, 0, 1);
        add(0, 2, 0,  0, 0, 0, 0, 0);
        add(1, 3, 0,  0, 1, 0, 0, 0);
        add(1, 3, 1,  0, 0, 1, 0, 0);
        add(1, 3, 0,  0, 1, 0, 0, 1);
        add(1, 3, 1,  0, 0, 1, 0, 1);
        add(1, 3, 0,  0, 1, 0, 1, 2);
        add(1, 3, 1,  0, 0, 1, 1, 2);
        add(1, 3, 0,  1, 0, 0, 0, 2);
        add(0, 3, 0,  0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            lr0 = vq[i].lr; iters0 = vq[i].iters; ra0 = vq[i].ra;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), pack0(),
                {21'd0, vq[i].la, vq[i].rr, vq[i].ck, vq[i].last, vq[i].idx});
        end

        // SYNC=2, iters=127, partner answers after 0-5 cycles.
        @(negedge clk);
        lr2 = 1'b1; iters2 = 7'd127;
        ck_cnt = 0; idx_err = 0; last_err = 0; done = 1'b0;
        dly = $urandom_range(0, 5);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (ck_cnt > 0) iters2 = 7'd5;
            if (ck2) begin
                if (idx2 != 7'(ck_cnt)) idx_err++;
                if (last2 != (ck_cnt == 126)) last_err++;
                ck_cnt++;
            end
            if (la2) begin
                done = 1'b1;
            end else if (rr2 != ra2) begin
                if (dly == 0) begin
                    ra2 = rr2;
                    dly = $urandom_range(0, 5);
                end else begin
                    dly--;
                end
            end
        end
        chk("s2_la_rise", {31'd0, done}, 32'd1);
        chk("s2_ck_count", 32'(ck_cnt), 32'd127);
        chk("s2_final_idx", {25'd0, idx2}, 32'd126);
        chk("s2_idx_seq_err", 32'(idx_err), 32'd0);
        chk("s2_last_err", 32'(last_err), 32'd0);
        lr2 = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!la2) done = 1'b1;
        end
        chk("s2_la_fall", {31'd0, done}, 32'd1);
        chk("s2_idx_cleared", {25'd0, idx2}, 32'd0);

`ifdef GO_SYNC_ABORT_EN
        // Abort raised during the idx=2 request completes that handshake, then ACK.
        @(negedge clk);
        lr0 = 1'b1; iters0 = 7'd10; ra0 = 1'b0;
        ck_cnt = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            abort0 = 1'b0;
            if (ck0) ck_cnt++;
            if (la0) begin
                done = 1'b1;
            end else begin
                if (rr0 && idx0 == 7'd2 && !ra0) abort0 = 1'b1;
                ra0 = rr0;
            end
        end
        chk("abort_la", {31'd0, done}, 32'd1);
        chk("abort_flag", {31'd0, aborted0}, 32'd1);
        chk("abort_ck_count", 32'(ck_cnt), 32'd3);
        chk("abort_idx", {25'd0, idx0}, 32'd2);
        lr0 = 1'b0;
        @(negedge clk);
        chk("abort_clear", {30'd0, la0, aborted0}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
